btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
- Sits downstream of four debounced button instances (north, east, south, west), each of which presents a clean level that changes once per physical press or release.
- Decodes those levels into discrete press events, classifies each press as short or long by hold time, and queues the events per button.
- Delivers the events one at a time to the game FSM over a valid/ack handshake.

Parameters:
LONG_TIME, 25000000, hold duration in clk cycles at which a press becomes long (0.5 s at 50 MHz); must be >= 2
CW, 25, hold counter width; must satisfy 2^CW > LONG_TIME

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous active-high reset
btn_in  input  4  debounced button levels, bit0=north, bit1=east, bit2=south, bit3=west; 1=pressed
evt_ack  input  1  consumer accepts the presented event (only meaningful while evt_valid=1)
evt_valid  output  1  an event is presented on evt_code/evt_long
evt_code  output  2  button index of the presented event (0=north .. 3=west)
evt_long  output  1  1=long press, 0=short press
btn_held  output  4  registered copy of btn_in (current pressed state)
overrun  output  1  sticky flag: an event was dropped because its pending slot was full

Behaviour:
- Reset (rst=1 at a clk edge):
  - evt_valid=0, evt_code=0, evt_long=0, overrun=0.
  - All pending bits and hold counters are cleared; long_done bits are cleared.
  - prev and btn_held load the current btn_in, so no edge is seen on the first cycle after reset.
  - A button held through reset is treated as pressed from the reset edge; its hold counter starts at 0.
- Edge detection per button i, evaluated each cycle:
  - rise = btn_in[i] & ~prev[i]; fall = ~btn_in[i] & prev[i]; prev <= btn_in.
  - btn_held <= btn_in.
- Hold counter per button i:
  - rise: counter cleared to 0 and long_done[i] cleared.
  - While btn_in[i]=1 and counter < LONG_TIME: counter increments by 1.
  - At counter == LONG_TIME: counter saturates and does not wrap.
  - When the counter first reaches LONG_TIME-1 with the button still held: long_pend[i] is set and long_done[i] is set. The long event therefore appears exactly LONG_TIME cycles after the rise, while the button is still down.
- Release: on fall, if long_done[i]=0 then short_pend[i] is set. If long_done[i]=1, no event is generated (a long press produces exactly one event).
- Overrun: setting a pending bit that is already set drops the new event and sets overrun. overrun clears only on rst.
- Output register (single entry):
  - Loads when evt_valid=0, or when evt_valid=1 and evt_ack=1 in the same cycle (back-to-back delivery with zero bubble).
  - Selection is fixed priority by lowest index first (north highest). Within one button, long_pend is taken before short_pend.
  - The selected pending bit clears in the same cycle the register loads.
  - When nothing is pending, evt_valid goes to 0 after an ack.
- Handshake:
  - evt_code and evt_long are stable while evt_valid=1 and evt_ack=0.
  - evt_ack while evt_valid=0 is ignored.
- Simultaneous events:
  - A pending bit set and selected in the same cycle: the new set is captured, so the event is not lost and a later set is not an overrun. Selection uses the pre-update pending vector; a set arriving that cycle is serviced in a later cycle.
  - Multiple buttons with edges in one cycle: all are recorded, then delivered in priority order.
- Latency:
  - Release edge to evt_valid=1 is 2 cycles when the output register is empty: pending set on cycle 1, presented on cycle 2.
  - Long event is presented at rise+LONG_TIME+1.
- A press shorter than one cycle cannot occur (inputs are debounced levels); a 1-cycle press still yields one short event.

Test Plan (LONG_TIME=8, CW=4):
- Reset with btn_in=0000, then pulse north for 3 cycles, evt_ack held 1 -> one cycle of evt_valid=1, evt_code=0, evt_long=0, 2 cycles after the fall; overrun=0.
- Hold east for 20 cycles, evt_ack=1 -> evt_valid at rise+9 with code=1, long=1; no event on release.
- evt_ack=0; press and release south, then west (each short) -> south (code=2) held stable; after one ack cycle, west (code=3) is presented on the next cycle; after a second ack, evt_valid=0.
- evt_ack=0; all four buttons rise in the same cycle and fall 3 cycles later -> events delivered in order 0,1,2,3 as acks arrive, each long=0.
- evt_ack=0; short-press north twice while the first north event is still pending and the output register is full -> one event retained for that slot, overrun=1 and remaining 1 until rst.
- Hold north through rst, release at rst+4 -> exactly one short north event; no event is generated by the reset itself.

Source files
------------

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - debounced button levels to queued short/long press events
//
// Purpose: detects press/release edges on four debounced buttons, times each
// press against LONG_TIME, keeps one short and one long pending slot per
// button, and presents events one at a time over a valid/ack handshake.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   btn_in     debounced levels, bit0=north .. bit3=west, 1=pressed
//   evt_ack    consumer accepts the presented event
//   evt_valid  an event is presented on evt_code/evt_long
//   evt_code   button index of the presented event
//   evt_long   1=long press, 0=short press
//   btn_held   registered copy of btn_in
//   overrun    sticky: an event was dropped because its slot was full
module btn_event_decoder #(
  parameter int LONG_TIME = 25000000,
  parameter int CW        = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  input  logic       evt_ack,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       evt_long,
  output logic [3:0] btn_held,
  output logic       overrun
);

  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_TIME);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TIME - 1);

  // held_q doubles as the previous-cycle sample used for edge detection
  logic [3:0]    held_q, held_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    long_done_q, long_done_d;
  logic [3:0]    long_pend_q, long_pend_d;
  logic [3:0]    short_pend_q, short_pend_d;
  logic          valid_q, valid_d;
  logic [1:0]    code_q, code_d;
  logic          elong_q, elong_d;
  logic          overrun_q, overrun_d;

  logic [3:0]    set_long, set_short;
  logic [3:0]    clr_long, clr_short;
  logic          load;
  logic          found;

  // Edge detection and hold timing
  always_comb begin
    held_d      = btn_in;
    long_done_d = long_done_q;
    set_long    = '0;
    set_short   = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (btn_in[i] && !held_q[i]) begin
        cnt_d[i]       = '0;
        long_done_d[i] = 1'b0;
      end else if (btn_in[i]) begin
        if (cnt_q[i] < LONG_MAX) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
        // Firing on LONG_LAST puts the event LONG_TIME cycles after the rise
        if (cnt_q[i] == LONG_LAST && !long_done_q[i]) begin
          set_long[i]    = 1'b1;
          long_done_d[i] = 1'b1;
        end
      end else if (held_q[i] && !long_done_q[i]) begin
        set_short[i] = 1'b1;
      end
    end
  end

  // Output register load, priority selection and pending update
  always_comb begin
    load      = !valid_q || evt_ack;
    valid_d   = valid_q;
    code_d    = code_q;
    elong_d   = elong_q;
    clr_long  = '0;
    clr_short = '0;
    found     = 1'b0;
    if (load) begin
      valid_d = 1'b0;
      // Selection looks only at the pre-update vector; same-cycle sets wait
      for (int i = 0; i < 4; i++) begin
        if (!found && (long_pend_q[i] || short_pend_q[i])) begin
          found   = 1'b1;
          valid_d = 1'b1;
          code_d  = 2'(i);
          elong_d = long_pend_q[i];
          if (long_pend_q[i]) begin
            clr_long[i] = 1'b1;
          end else begin
            clr_short[i] = 1'b1;
          end
        end
      end
    end
    // A slot being drained this cycle can accept a new set without overrun
    long_pend_d  = (long_pend_q & ~clr_long) | set_long;
    short_pend_d = (short_pend_q & ~clr_short) | set_short;
    overrun_d    = overrun_q
                 | (|(set_long & long_pend_q & ~clr_long))
                 | (|(set_short & short_pend_q & ~clr_short));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q       <= btn_in;
      long_done_q  <= '0;
      long_pend_q  <= '0;
      short_pend_q <= '0;
      valid_q      <= 1'b0;
      code_q       <= '0;
      elong_q      <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      held_q       <= held_d;
      long_done_q  <= long_done_d;
      long_pend_q  <= long_pend_d;
      short_pend_q <= short_pend_d;
      valid_q      <= valid_d;
      code_q       <= code_d;
      elong_q      <= elong_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign evt_valid = valid_q;
  assign evt_code  = code_q;
  assign evt_long  = elong_q;
  assign btn_held  = held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - scoreboard bench for btn_event_decoder
module tb_btn_event_decoder;

  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic       evt_ack;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_long;
  logic [3:0] btn_held;
  logic       overrun;

  always #5 clk = ~clk;

  btn_event_decoder #(.LONG_TIME(L), .CW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .evt_ack   (evt_ack),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_long  (evt_long),
    .btn_held  (btn_held),
    .overrun   (overrun)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0] code;
    logic       lng;
  } evt_t;

  evt_t exp_q[$];

  // Reference model: run length of consecutive pressed samples per button,
  // one short and one long slot per button, one presented event.
  bit         m_valid;
  bit         m_ovr;
  bit         m_just_rst;
  logic [3:0] m_prev;
  int         m_run [4];
  bit         m_pend [4][2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic post(input int i, input int k);
    if (m_pend[i][k]) m_ovr = 1'b1;
    else m_pend[i][k] = 1'b1;
  endtask

  task automatic model_step();
    if (rst) begin
      exp_q.delete();
      m_valid    = 1'b0;
      m_ovr      = 1'b0;
      m_just_rst = 1'b1;
      m_prev     = btn_in;
      for (int i = 0; i < 4; i++) begin
        m_run[i]     = btn_in[i] ? 1 : 0;
        m_pend[i][0] = 1'b0;
        m_pend[i][1] = 1'b0;
      end
    end else begin
      m_just_rst = 1'b0;
      if (!m_valid || evt_ack) begin
        m_valid = 1'b0;
        for (int i = 0; i < 4 && !m_valid; i++) begin
          for (int k = 1; k >= 0 && !m_valid; k--) begin
            if (m_pend[i][k]) begin
              m_pend[i][k] = 1'b0;
              exp_q.push_back({i[1:0], k[0]});
              m_valid = 1'b1;
            end
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (btn_in[i]) begin
          m_run[i] = m_prev[i] ? m_run[i] + 1 : 1;
          if (m_run[i] == L + 1) post(i, 1);
        end else if (m_prev[i] && m_run[i] <= L) begin
          post(i, 0);
        end
      end
      m_prev = btn_in;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: pops expected events whenever the DUT presents a new one
  logic       p_valid = 1'b0;
  logic       p_ack   = 1'b0;
  logic [1:0] p_code  = '0;
  logic       p_long  = 1'b0;

  initial begin
    evt_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("evt_valid", evt_valid, m_valid);
      chk("overrun", overrun, m_ovr);
      chk("btn_held", btn_held, m_prev);
      if (m_just_rst) begin
        chk("rst_code", evt_code, 0);
        chk("rst_long", evt_long, 0);
      end
      if (evt_valid === 1'b1) begin
        if (!p_valid || p_ack) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_evt: got code %0d long %0d expected none at %0t",
                     evt_code, evt_long, $time);
          end else begin
            e = exp_q.pop_front();
            chk("evt_code", evt_code, e.code);
            chk("evt_long", evt_long, e.lng);
          end
        end else begin
          chk("hold_code", evt_code, p_code);
          chk("hold_long", evt_long, p_long);
        end
      end
      p_valid = evt_valid;
      p_ack   = evt_ack;
      p_code  = evt_code;
      p_long  = evt_long;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    btn_in  = 4'b0000;
    evt_ack = 1'b0;
    step(2);
    rst = 1'b0;

    // short north press, ack held
    evt_ack = 1'b1;
    btn_in  = 4'b0001; step(3);
    btn_in  = 4'b0000; step(6);

    // long east press
    btn_in = 4'b0010; step(20);
    btn_in = 4'b0000; step(5);

    // south then west short, held off by ack
    evt_ack = 1'b0;
    btn_in  = 4'b0100; step(2);
    btn_in  = 4'b0000; step(2);
    btn_in  = 4'b1000; step(2);
    btn_in  = 4'b0000; step(6);
    evt_ack = 1'b1; step(1);
    evt_ack = 1'b0; step(2);
    evt_ack = 1'b1; step(1);
    evt_ack = 1'b0; step(3);

    // all four at once
    btn_in = 4'b1111; step(3);
    btn_in = 4'b0000; step(4);
    repeat (4) begin
      evt_ack = 1'b1; step(1);
      evt_ack = 1'b0; step(2);
    end
    step(2);

    // repeated north presses into a full slot
    repeat (3) begin
      btn_in = 4'b0001; step(2);
      btn_in = 4'b0000; step(2);
    end
    step(3);
    evt_ack = 1'b1; step(6);
    evt_ack = 1'b0; step(2);

    // north held through reset
    btn_in = 4'b0001; step(2);
    rst    = 1'b1;    step(1);
    rst    = 1'b0;    step(4);
    btn_in  = 4'b0000;
    evt_ack = 1'b1;   step(6);

    // randomized phase
    repeat (3000) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(9) == 0) btn_in[i] = ~btn_in[i];
      end
      evt_ack = 1'($urandom_range(1));
      rst     = ($urandom_range(499) == 0);
      step(1);
    end
    rst     = 1'b0;
    btn_in  = 4'b0000;
    evt_ack = 1'b1;
    step(20);
    chk("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
